// File: rtl/velmshift_pkg.sv
// Shared types and helpers for the vector element shifter sequencer.
// Optional rotate support is enabled with the VELMSHIFT_ROTATE_EN macro.
package velmshift_pkg;

  localparam int VS_NUMLANES     = 4;
  localparam int VS_LOG2NUMLANES = 2;
  localparam int VS_CNT_W        = VS_LOG2NUMLANES + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift amounts beyond the lane count behave like a full-width shift.
  function automatic int unsigned vs_clamp(input int unsigned amt, input int unsigned lim);
    return (amt > lim) ? lim : amt;
  endfunction

endpackage

// File: rtl/velmshift_squashgen.sv
// Thermometer mask from vector length: lane i is squashed when i >= vl.
module velmshift_squashgen #(
  parameter int NUMLANES = 4,
  parameter int CW       = 3
) (
  input  logic [CW-1:0]       vl_i,
  output logic [NUMLANES-1:0] squash_o
);

  always_comb begin
    squash_o = '0;
    for (int i = 0; i < NUMLANES; i++) begin
      squash_o[i] = (i >= int'(vl_i));
    end
  end

endmodule

// File: rtl/velmshift_ctrl.sv
// Control sequencer for velmshifter: load, shift strobes and done pulse per command.
// Define VELMSHIFT_ROTATE_EN to latch cmd_rotate and drive shiftin_rotate.
module velmshift_ctrl
  import velmshift_pkg::*;
#(
  parameter int NUMLANES     = VS_NUMLANES,
  parameter int LOG2NUMLANES = VS_LOG2NUMLANES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir_left,
  input  logic [LOG2NUMLANES:0]   cmd_amount,
  input  logic [LOG2NUMLANES:0]   cmd_vl,
  input  logic                    cmd_rotate,
  input  logic                    stall,
  output logic                    load,
  output logic                    shift,
  output logic                    dir_left,
  output logic [NUMLANES-1:0]     squash,
  output logic                    shiftin_rotate,
  output logic                    busy,
  output logic                    done,
  output state_t                  dbg_state_o
);

  localparam int CW = LOG2NUMLANES + 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       vl_q, vl_d;
  logic                dir_q, dir_d;
  logic [NUMLANES-1:0] mask;
  logic                take;
  logic                rot_next;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; the requester holds fields stable until then.
  assign take        = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign dbg_state_o = state_q;

  velmshift_squashgen #(
    .NUMLANES (NUMLANES),
    .CW       (CW)
  ) u_squashgen (
    .vl_i     (vl_d),
    .squash_o (mask)
  );

`ifdef VELMSHIFT_ROTATE_EN
  logic rot_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_q <= 1'b0;
    end else if (take) begin
      rot_q <= cmd_rotate;
    end
  end
  assign rot_next = (state_d != IDLE) && (take ? cmd_rotate : rot_q);
`else
  logic unused_rot;
  assign unused_rot = cmd_rotate;
  assign rot_next   = 1'b0;
`endif

  // The phase advances only after its strobe actually went out, so a
  // stalled (zeroed) strobe cycle leaves state and counter untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vl_d    = vl_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = LOAD;
          cnt_d   = CW'(vs_clamp(int'(cmd_amount), NUMLANES));
          vl_d    = cmd_vl;
          dir_d   = cmd_dir_left;
        end
      end
      LOAD: begin
        if (load) begin
          state_d = (cnt_q == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (shift) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      vl_q           <= '0;
      dir_q          <= 1'b0;
      cmd_ready      <= 1'b1;
      load           <= 1'b0;
      shift          <= 1'b0;
      dir_left       <= 1'b0;
      squash         <= '0;
      shiftin_rotate <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      vl_q           <= vl_d;
      dir_q          <= dir_d;
      cmd_ready      <= (state_d == IDLE);
      load           <= (state_d == LOAD) && !stall;
      shift          <= (state_d == SHIFT) && !stall;
      dir_left       <= (state_d != IDLE) && dir_d;
      squash         <= (state_d != IDLE) ? mask : '0;
      shiftin_rotate <= rot_next;
      busy           <= (state_d != IDLE);
      done           <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_velmshift_ctrl.sv
// Self-checking bench for velmshift_ctrl: randomized commands and stalls,
// expected results from a cycle-budget model pushed to a scoreboard queue.
module tb_velmshift_ctrl;
  import velmshift_pkg::*;

  localparam int NL = 4;
  localparam int CW = VS_CNT_W;
  localparam int RW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir_left = 1'b0;
  logic [CW-1:0] cmd_amount = '0;
  logic [CW-1:0] cmd_vl = '0;
  logic          cmd_rotate = 1'b0;
  logic          stall = 1'b0;
  logic          load, shift, dir_left, shiftin_rotate, busy, done;
  logic [NL-1:0] squash;
  state_t        dbg_state;

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] exp_q[$];
  bit            stall_pat[64];
  bit            mon_en = 1'b0;

  always #5 clk = ~clk;

  velmshift_ctrl #(.NUMLANES(NL), .LOG2NUMLANES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dir_left   (cmd_dir_left),
    .cmd_amount     (cmd_amount),
    .cmd_vl         (cmd_vl),
    .cmd_rotate     (cmd_rotate),
    .stall          (stall),
    .load           (load),
    .shift          (shift),
    .dir_left       (dir_left),
    .squash         (squash),
    .shiftin_rotate (shiftin_rotate),
    .busy           (busy),
    .done           (done),
    .dbg_state_o    (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_amt(input int a);
    return (a > NL) ? NL : a;
  endfunction

  function automatic logic [NL-1:0] model_squash(input int vl);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    if (vl >= NL) return '0;
    return NL'(ones << vl);
  endfunction

  // One load plus amt shifts must each find an unstalled cycle; stall_pat[k]
  // is the stall value seen by the edge that opens cycle k after acceptance.
  function automatic int model_latency(input int amt);
    int work;
    int k;
    work = 1 + amt;
    k = 0;
    while (work > 0 && k < 60) begin
      k++;
      if (!stall_pat[k]) work--;
    end
    return k + 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_pat();
    for (int k = 0; k < 64; k++) stall_pat[k] = 1'b0;
  endtask

  task automatic rand_pat(input int pct);
    clear_pat();
    for (int k = 1; k < 13; k++) stall_pat[k] = ($urandom_range(99) < pct);
  endtask

  task automatic present(input bit dir, input int amt, input int vl, input bit rot);
    cmd_valid    = 1'b1;
    cmd_dir_left = dir;
    cmd_amount   = CW'(amt);
    cmd_vl       = CW'(vl);
    cmd_rotate   = rot;
  endtask

  task automatic wait_accept(output int lat);
    int  guard;
    int  ac;
    logic exp_rot;
    guard = 0;
    lat = 0;
    while (cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=%0b expected 1 within 200 cycles", cmd_ready);
      return;
    end
    stall = stall_pat[1];
    @(negedge clk);
    ac  = clamp_amt(int'(cmd_amount));
    lat = model_latency(ac);
`ifdef VELMSHIFT_ROTATE_EN
    exp_rot = cmd_rotate;
`else
    exp_rot = 1'b0;
`endif
    exp_q.push_back({8'(lat), 4'(ac), model_squash(int'(cmd_vl)), cmd_dir_left, exp_rot});
  endtask

  task automatic run_stalls(input int lat);
    for (int k = 1; k <= lat; k++) begin
      stall = stall_pat[k + 1];
      @(negedge clk);
    end
    stall = 1'b0;
  endtask

  task automatic issue(input bit dir, input int amt, input int vl, input bit rot);
    int lat;
    present(dir, amt, vl, rot);
    wait_accept(lat);
    cmd_valid = 1'b0;
    run_stalls(lat);
  endtask

  // Second command is presented while the first is still in flight.
  task automatic b2b(input bit da, input int aa, input int va, input bit ra,
                     input bit db, input int ab, input int vb, input bit rb, input int pct);
    int la;
    int lb;
    rand_pat(pct);
    present(da, aa, va, ra);
    wait_accept(la);
    present(db, ab, vb, rb);
    run_stalls(la);
    rand_pat(pct);
    wait_accept(lb);
    cmd_valid = 1'b0;
    run_stalls(lb);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            acc_s, rst_s, active;
  int            cyc, n_load, n_shift;
  logic [NL-1:0] sq0;
  logic          dir0, rot0;
  logic [RW-1:0] e;

  always @(posedge clk) begin
    rst_s = reset;
    acc_s = cmd_valid && cmd_ready && !reset;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_s) begin
        active = 1'b0;
      end else if (acc_s) begin
        active  = 1'b1;
        cyc     = 0;
        n_load  = 0;
        n_shift = 0;
        sq0     = squash;
        dir0    = dir_left;
        rot0    = shiftin_rotate;
      end
      if (active) begin
        cyc++;
        chk("busy_high", busy, 1);
        chk("ready_low", cmd_ready, 0);
        if (cyc > 1) begin
          chk("squash_hold", squash, sq0);
          chk("dir_hold", dir_left, dir0);
          chk("rot_hold", shiftin_rotate, rot0);
        end
        n_load  += int'(load);
        n_shift += int'(shift);
        if (done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending command");
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc, e[17:10]);
            chk("shift_count", n_shift, e[9:6]);
            chk("load_count", n_load, 1);
            chk("squash", sq0, e[5:2]);
            chk("dir_left", dir0, e[1]);
            chk("shiftin_rotate", rot0, e[0]);
          end
          active = 1'b0;
        end else if (cyc > 100) begin
          checks++;
          errors++;
          $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
          active = 1'b0;
        end
      end else begin
        chk("idle_load", load, 0);
        chk("idle_shift", shift, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_dir", dir_left, 0);
        chk("idle_squash", squash, 0);
        chk("idle_rot", shiftin_rotate, 0);
        chk("idle_ready", cmd_ready, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    clear_pat();
    repeat (3) @(negedge clk);
    chk("reset_state", dbg_state, IDLE);
    chk("reset_ready", cmd_ready, 1);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // basic, zero amount, clamp with stall in SHIFT
    clear_pat();
    issue(1'b1, 2, 4, 1'b0);
    issue(1'b0, 0, 3, 1'b0);
    clear_pat();
    stall_pat[3] = 1'b1;
    stall_pat[4] = 1'b1;
    issue(1'b1, 7, 4, 1'b0);

    // reset mid-operation: no done for the aborted command
    clear_pat();
    present(1'b0, 3, 2, 1'b0);
    wait_accept(lat);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midop_reset_state", dbg_state, IDLE);
    chk("midop_reset_busy", busy, 0);
    chk("midop_reset_ready", cmd_ready, 1);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // back-to-back with valid held, then rotate
    b2b(1'b1, 2, 2, 1'b0, 1'b0, 1, 4, 1'b0, 0);
    clear_pat();
    issue(1'b0, 1, 4, 1'b1);

    // randomized commands and stalls
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(1) == 1) begin
        b2b(1'($urandom_range(1)), $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)),
            1'($urandom_range(1)), $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)), 30);
      end else begin
        rand_pat(30);
        issue(1'($urandom_range(1)), $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)));
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
